// File: rtl/hack_pkg.sv
// Shared definitions for the Hack control core: sequencer states, instruction
// field positions and jump-condition encodings.
package hack_pkg;

    typedef enum logic [2:0] {
        RST,
        FETCH,
        DECODE,
        READ_M,
        EXEC,
        WRITE_M
    } state_e;

    localparam int CI_BIT   = 15;
    localparam int A_BIT    = 12;
    localparam int CTL_MSB  = 11;
    localparam int CTL_LSB  = 6;
    localparam int DEST_MSB = 5;
    localparam int DEST_LSB = 3;
    localparam int JMP_MSB  = 2;
    localparam int JMP_LSB  = 0;

    localparam logic [2:0] JMP_NULL = 3'b000;
    localparam logic [2:0] JMP_ALL  = 3'b111;

endpackage

// File: rtl/hack_jump_eval.sv
// Combinational Hack jump decision from the j1/j2/j3 field and the ALU flags.
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [2:0] j_i,
    input  logic       zr_i,
    input  logic       ng_i,
    output logic       take_o
);

    always_comb begin
        take_o = 1'b0;
        if (j_i == JMP_ALL) begin
            take_o = 1'b1;
        end else if (j_i != JMP_NULL) begin
            take_o = (j_i[2] & ng_i) | (j_i[1] & zr_i) | (j_i[0] & ~ng_i & ~zr_i);
        end
    end

endmodule

// File: rtl/hack_cpu_sequencer.sv
// Multi-cycle Hack-ISA sequencer: owns A/D/PC/IR, fetches over a req/ack port,
// reads/writes data memory and steers an external 16-bit ALU.
module hack_cpu_sequencer
    import hack_pkg::*;
#(
    parameter int IMEM_AW = 15,
    parameter int DMEM_AW = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [15:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [15:0]        dmem_rdata,
    output logic [15:0]        alu_x,
    output logic [15:0]        alu_y,
    output logic [5:0]         alu_ctl,
    input  logic [15:0]        alu_out,
    input  logic               alu_zr,
    input  logic               alu_ng,
    output logic               retire,
    output logic [IMEM_AW-1:0] pc
);

    localparam logic [IMEM_AW-1:0] PC_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [15:0]          a_q, a_d, d_q, d_d, ir_q, ir_d, m_q, m_d;
    logic [IMEM_AW-1:0]   pc_q, pc_d;
    logic                 imem_req_q, imem_req_d;
    logic                 dmem_req_q, dmem_req_d;
    logic                 dmem_we_q, dmem_we_d;
    logic [DMEM_AW-1:0]   dmem_addr_q, dmem_addr_d;
    logic [15:0]          dmem_wdata_q, dmem_wdata_d;
    logic                 retire_q, retire_d;
    logic [2:0]           dest;
    logic                 jump_take;

    assign dest = ir_q[DEST_MSB:DEST_LSB];

    hack_jump_eval u_jump (
        .j_i    (ir_q[JMP_MSB:JMP_LSB]),
        .zr_i   (alu_zr),
        .ng_i   (alu_ng),
        .take_o (jump_take)
    );

    // NOTE: every next-state value gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        d_d          = d_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        m_d          = m_q;
        imem_req_d   = imem_req_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        retire_d     = 1'b0;
        alu_ctl      = 6'b0;

        // Request states spend one cycle raising req, then wait for ack with req held.
        case (state_q)
            RST: state_d = FETCH;
            FETCH: begin
                if (!imem_req_q) begin
                    imem_req_d = 1'b1;
                end else if (imem_ack) begin
                    imem_req_d = 1'b0;
                    ir_d       = imem_rdata;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                if (!ir_q[CI_BIT]) begin
                    a_d      = {1'b0, ir_q[CI_BIT-1:0]};
                    pc_d     = pc_q + PC_ONE;
                    retire_d = 1'b1;
                    state_d  = FETCH;
                end else if (ir_q[A_BIT]) begin
                    dmem_addr_d = a_q[DMEM_AW-1:0];
                    state_d     = READ_M;
                end else begin
                    state_d = EXEC;
                end
            end
            READ_M: begin
                if (!dmem_req_q) begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = 1'b0;
                end else if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    m_d        = dmem_rdata;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                alu_ctl = ir_q[CTL_MSB:CTL_LSB];
                // Jump target and write address both use A as it was before this instruction.
                pc_d         = jump_take ? a_q[IMEM_AW-1:0] : pc_q + PC_ONE;
                dmem_addr_d  = a_q[DMEM_AW-1:0];
                dmem_wdata_d = alu_out;
                if (dest[1]) d_d = alu_out;
                if (dest[2]) a_d = alu_out;
                if (dest[0]) begin
                    state_d = WRITE_M;
                end else begin
                    retire_d = 1'b1;
                    state_d  = FETCH;
                end
            end
            WRITE_M: begin
                if (!dmem_req_q) begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = 1'b1;
                end else if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    retire_d   = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = RST;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST;
            a_q          <= 16'h0;
            d_q          <= 16'h0;
            pc_q         <= '0;
            ir_q         <= 16'h0;
            m_q          <= 16'h0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 16'h0;
            retire_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            d_q          <= d_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            m_q          <= m_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            retire_q     <= retire_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign alu_x      = d_q;
    assign alu_y      = ir_q[A_BIT] ? m_q : a_q;
    assign retire     = retire_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// Directed bench for hack_cpu_sequencer: Hack ALU, ROM program and data memory
// with programmable ack delays around the DUT.
module tb_hack_cpu_sequencer;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr, pc;
    logic [15:0]   imem_rdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] dmem_addr;
    logic [15:0]   dmem_wdata, dmem_rdata;
    logic [15:0]   alu_x, alu_y, alu_out;
    logic [5:0]    alu_ctl;
    logic          alu_zr, alu_ng, retire;

    int imem_delay = 0;
    int dmem_delay = 0;
    int im_wcnt, dm_wcnt;
    int checks = 0;
    int errors = 0;

    logic [15:0] dmem [0:31];
    bit          dmem_loaded = 1'b0;
    logic [AW-1:0] last_wr_addr, last_rd_addr;
    logic [15:0]   last_wr_data;

    int ncyc = 0, prev_ret = 0, last_lat = 0, retire_cnt = 0;
    int imem_req_cnt = 0, dmem_req_cnt = 0, stab_err = 0;
    logic [5:0]    last_ctl = 6'b0;
    logic          im_prev = 1'b0, dm_prev = 1'b0;
    logic [AW-1:0] im_hold, dm_hold_addr;
    logic          dm_hold_we;
    logic [15:0]   dm_hold_wdata;

    always #5 clk = ~clk;

    hack_cpu_sequencer #(.IMEM_AW(AW), .DMEM_AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctl    (alu_ctl),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .retire     (retire),
        .pc         (pc)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    function automatic logic [15:0] rom(input logic [AW-1:0] a);
        case (a)
            15'd0:     return 16'h0015;  // @21
            15'd1:     return 16'hEC10;  // D=A
            15'd2:     return 16'hF090;  // D=D+M
            15'd3:     return 16'hFDE8;  // AM=M+1
            15'd4:     return 16'h0064;  // @100
            15'd5:     return 16'hEA87;  // 0;JMP
            15'd100:   return 16'hEA90;  // D=0
            15'd101:   return 16'hE301;  // D;JGT
            15'd102:   return 16'h7FFF;  // @32767
            15'd103:   return 16'hEA87;  // 0;JMP
            15'd32767: return 16'h0007;  // @7, PC wraps
            default:   return 16'h0000;
        endcase
    endfunction

    assign alu_out    = hack_alu(alu_x, alu_y, alu_ctl);
    assign alu_zr     = (alu_out == 16'h0);
    assign alu_ng     = alu_out[15];
    assign imem_ack   = imem_req && (im_wcnt == imem_delay);
    assign imem_rdata = rom(imem_addr);
    assign dmem_ack   = dmem_req && (dm_wcnt == dmem_delay);
    assign dmem_rdata = dmem[dmem_addr[4:0]];

    // Memory models: ack after a programmable number of waiting cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_wcnt <= 0;
            dm_wcnt <= 0;
            if (!dmem_loaded) begin
                for (int k = 0; k < 32; k++) dmem[k] <= 16'h0;
                dmem[21]    <= 16'h0005;
                dmem_loaded <= 1'b1;
            end
        end else begin
            im_wcnt <= (imem_req && !imem_ack) ? im_wcnt + 1 : 0;
            dm_wcnt <= (dmem_req && !dmem_ack) ? dm_wcnt + 1 : 0;
            if (dmem_req && dmem_ack) begin
                if (dmem_we) begin
                    dmem[dmem_addr[4:0]] <= dmem_wdata;
                    last_wr_addr         <= dmem_addr;
                    last_wr_data         <= dmem_wdata;
                end else begin
                    last_rd_addr <= dmem_addr;
                end
            end
        end
    end

    // Retire latency, ALU control capture, request counting and stability.
    always @(negedge clk) begin
        ncyc++;
        if (retire) begin
            retire_cnt++;
            last_lat = ncyc - prev_ret;
            prev_ret = ncyc;
        end
        if (alu_ctl != 6'b0) last_ctl = alu_ctl;
        if (imem_req) begin
            if (!im_prev) begin
                imem_req_cnt++;
                im_hold = imem_addr;
            end else if (imem_addr !== im_hold) begin
                stab_err++;
            end
        end
        if (dmem_req) begin
            if (!dm_prev) begin
                dmem_req_cnt++;
                dm_hold_addr  = dmem_addr;
                dm_hold_we    = dmem_we;
                dm_hold_wdata = dmem_wdata;
            end else if (dmem_addr !== dm_hold_addr || dmem_we !== dm_hold_we ||
                         dmem_wdata !== dm_hold_wdata) begin
                stab_err++;
            end
        end
        im_prev = imem_req;
        dm_prev = dmem_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic wait_retire(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (retire) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_retire_seen"}, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int base_ret, im_base, dm_base;

        // Abort a pending write with reset.
        rst_n      = 1'b1;
        dmem_delay = 40;
        #1 rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (dmem_req && dmem_we) begin
                seen = 1'b1;
                break;
            end
        end
        check("wr_req_seen", {31'b0, seen}, 32'd1);
        check("wr_addr_pending", 32'(dmem_addr), 32'd21);
        check("wr_data_pending", 32'(dmem_wdata), 32'h6);
        rst_n = 1'b0;
        #1;
        check("abort_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("abort_dmem_we", {31'b0, dmem_we}, 32'd0);
        check("abort_imem_req", {31'b0, imem_req}, 32'd0);
        check("abort_retire", {31'b0, retire}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("abort_mem_kept", 32'(dmem[21]), 32'h5);
        rst_n = 1'b1;
        #1;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_d", 32'(alu_x), 32'd0);
        check("rst_a", 32'(alu_y), 32'd0);
        check("rst_ctl", 32'(alu_ctl), 32'd0);
        check("rst_wdata", 32'(dmem_wdata), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (imem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("first_fetch_seen", {31'b0, seen}, 32'd1);
        check("first_fetch_addr", 32'(imem_addr), 32'd0);
        dmem_delay = 0;
        base_ret   = retire_cnt;

        // Zero-wait program run.
        wait_retire("i0");
        check("i0_pc", 32'(pc), 32'd1);
        check("i0_a", 32'(alu_y), 32'h15);
        wait_retire("i1");
        check("i1_ctl", 32'(last_ctl), 32'b110000);
        check("i1_d", 32'(alu_x), 32'h15);
        check("i1_pc", 32'(pc), 32'd2);
        check("i1_retires", 32'(retire_cnt - base_ret), 32'd2);
        check("i1_lat", 32'(last_lat), 32'd4);
        wait_retire("i2");
        check("i2_rd_addr", 32'(last_rd_addr), 32'd21);
        check("i2_d", 32'(alu_x), 32'h1A);
        check("i2_m", 32'(alu_y), 32'h5);
        check("i2_ctl", 32'(last_ctl), 32'b000010);
        check("i2_lat", 32'(last_lat), 32'd6);
        wait_retire("i3");
        check("i3_wr_addr", 32'(last_wr_addr), 32'd21);
        check("i3_wr_data", 32'(last_wr_data), 32'h6);
        check("i3_mem", 32'(dmem[21]), 32'h6);
        check("i3_lat", 32'(last_lat), 32'd8);
        check("i3_d", 32'(alu_x), 32'h1A);
        @(negedge clk);
        #1;
        check("retire_pulse", {31'b0, retire}, 32'd0);
        @(negedge clk);
        #1;
        check("i3_a", 32'(alu_y), 32'h6);
        wait_retire("i4");
        check("i4_pc", 32'(pc), 32'd5);
        check("i4_a", 32'(alu_y), 32'd100);
        check("i4_lat", 32'(last_lat), 32'd3);
        wait_retire("i5");
        check("i5_pc_jmp", 32'(pc), 32'd100);
        check("i5_ctl", 32'(last_ctl), 32'b101010);
        check("i5_d", 32'(alu_x), 32'h1A);
        check("i5_lat", 32'(last_lat), 32'd4);
        wait_retire("i100");
        check("i100_pc", 32'(pc), 32'd101);
        check("i100_d", 32'(alu_x), 32'd0);
        wait_retire("i101");
        check("i101_pc_nojmp", 32'(pc), 32'd102);
        check("i101_ctl", 32'(last_ctl), 32'b001100);
        check("i101_lat", 32'(last_lat), 32'd4);
        wait_retire("i102");
        check("i102_pc", 32'(pc), 32'd103);
        wait_retire("i103");
        check("i103_pc", 32'(pc), 32'd32767);
        wait_retire("i32767");
        check("wrap_pc", 32'(pc), 32'd0);
        check("wrap_a", 32'(alu_y), 32'h7);

        // Same program again with slow memories.
        imem_delay = 3;
        dmem_delay = 2;
        im_base    = imem_req_cnt;
        dm_base    = dmem_req_cnt;
        wait_retire("j0");
        check("j0_lat", 32'(last_lat), 32'd6);
        wait_retire("j1");
        check("j1_lat", 32'(last_lat), 32'd7);
        check("j1_d", 32'(alu_x), 32'd21);
        wait_retire("j2");
        check("j2_lat", 32'(last_lat), 32'd11);
        check("j2_d", 32'(alu_x), 32'h1B);
        wait_retire("j3");
        check("j3_lat", 32'(last_lat), 32'd15);
        check("j3_wr_data", 32'(last_wr_data), 32'h7);
        check("j3_mem", 32'(dmem[21]), 32'h7);
        check("slow_imem_reqs", 32'(imem_req_cnt - im_base), 32'd4);
        check("slow_dmem_reqs", 32'(dmem_req_cnt - dm_base), 32'd3);
        check("req_stable", 32'(stab_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
